// File: rtl/opb_status_snapshot_pkg.sv
// Shared constants and types for the OPB status snapshot controller.
// Bit indices follow OPB big-endian numbering: bit 0 is the MSB, bit 31 the LSB.
package opb_status_snapshot_pkg;

  localparam logic [31:0] OffCtrl       = 32'h0000_0000;
  localparam logic [31:0] OffPeriod     = 32'h0000_0004;
  localparam logic [31:0] OffSnapCount  = 32'h0000_0008;
  localparam logic [31:0] OffShadowBase = 32'h0000_0010;

  localparam int unsigned CtrlSnapBit   = 31;
  localparam int unsigned CtrlAutoEnBit = 30;
  // Byte lane (OPB_BE index) that carries both CTRL bits.
  localparam int unsigned CtrlByte      = 3;

  typedef enum logic [1:0] {StIdle, StAck, StGap} state_e;

endpackage

// File: rtl/snapshot_timer.sv
// Periodic down-counter that fires once every period_i cycles while active.
// A reload restarts the count from period_i; going inactive clears it.
module snapshot_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic        reload_i,
  input  logic [31:0] period_i,
  output logic        fire_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = period_i;
    end else if (!active_i) begin
      cnt_d = '0;
    end else if (cnt_q <= 32'd1) begin
      cnt_d = period_i;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  // Firing on a count of 1 and reloading gives exactly period_i cycles between fires.
  assign fire_o = active_i && (cnt_q == 32'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/opb_status_snapshot_ctrl.sv
// OPB slave that captures all status words into shadow registers in one cycle, so software
// reads a coherent multi-word view. Snapshots come from CTRL.SNAP or a periodic timer.
module opb_status_snapshot_ctrl
  import opb_status_snapshot_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0106_1000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0106_10FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned N_WORDS      = 8
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [N_WORDS*32-1:0]   status_in,
  output logic                    snap_pulse
);

  state_e      state_q, state_d;
  logic        hit;
  logic [31:0] off_live, off_q;
  logic        rnw_q;
  logic [0:3]  be_q;
  logic [0:31] wdata_q;
  logic [0:31] rd_data, rdata_q;
  logic        auto_en_q, auto_en_d;
  logic [31:0] period_q, period_d;
  logic [31:0] snap_count_q, snap_count_d;
  logic [31:0] shadow_q [N_WORDS];
  logic        wr_ack, ctrl_wr, period_wr, manual_snap;
  logic        timer_active, timer_fire;
  logic        unused_ok;

  assign unused_ok = OPB_seqAddr;

  assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  // Byte-within-word address bits are dropped, so every access is word aligned.
  assign off_live = {OPB_ABus[0:C_OPB_AWIDTH-3], 2'b00} - C_BASEADDR;

  always_comb begin
    rd_data = '0;
    if (off_live == OffCtrl) begin
      rd_data[CtrlAutoEnBit] = auto_en_q;
    end else if (off_live == OffPeriod) begin
      rd_data = period_q;
    end else if (off_live == OffSnapCount) begin
      rd_data = snap_count_q;
    end else begin
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        if (off_live == OffShadowBase + 32'(4 * i)) rd_data = shadow_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hit) state_d = StAck;
      StAck:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read data is frozen on the hit edge, so a snapshot landing on that edge stays invisible.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      off_q   <= '0;
      rnw_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if ((state_q == StIdle) && hit) begin
      off_q   <= off_live;
      rnw_q   <= OPB_RNW;
      be_q    <= OPB_BE;
      wdata_q <= OPB_DBus;
      rdata_q <= OPB_RNW ? rd_data : '0;
    end
  end

  assign wr_ack      = (state_q == StAck) && !rnw_q;
  assign ctrl_wr     = wr_ack && (off_q == OffCtrl);
  assign period_wr   = wr_ack && (off_q == OffPeriod);
  assign manual_snap = ctrl_wr && be_q[CtrlByte] && wdata_q[CtrlSnapBit];

  always_comb begin
    auto_en_d = auto_en_q;
    period_d  = period_q;
    if (ctrl_wr && be_q[CtrlByte]) auto_en_d = wdata_q[CtrlAutoEnBit];
    if (period_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) period_d[31-8*b -: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  assign timer_active = auto_en_q && (period_q != '0);

  snapshot_timer u_timer (
    .clk_i    (OPB_Clk),
    .rst_i    (OPB_Rst),
    .active_i (timer_active),
    .reload_i (ctrl_wr || period_wr),
    .period_i (period_d),
    .fire_o   (timer_fire)
  );

  // Coincident manual and timer triggers merge into a single snapshot.
  assign snap_pulse   = manual_snap || timer_fire;
  assign snap_count_d = snap_pulse ? snap_count_q + 32'd1 : snap_count_q;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q      <= StIdle;
      auto_en_q    <= 1'b0;
      period_q     <= '0;
      snap_count_q <= '0;
      for (int unsigned i = 0; i < N_WORDS; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      auto_en_q    <= auto_en_d;
      period_q     <= period_d;
      snap_count_q <= snap_count_d;
      if (snap_pulse) begin
        for (int unsigned i = 0; i < N_WORDS; i++) shadow_q[i] <= status_in[32*i +: 32];
      end
    end
  end

  assign Sl_xferAck = (state_q == StAck);
  assign Sl_DBus    = Sl_xferAck ? rdata_q : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_status_snapshot_ctrl.sv
// Self-checking bench for opb_status_snapshot_ctrl: register table, manual/auto snapshots,
// coincident triggers, counter wrap and asynchronous reset during an acknowledge.
module tb_opb_status_snapshot_ctrl;

  localparam int unsigned NWords = 8;
  localparam logic [31:0] Base   = 32'h0106_1000;

  logic                 OPB_Clk = 1'b0;
  logic                 OPB_Rst = 1'b1;
  logic [0:31]          OPB_ABus = '0;
  logic [0:3]           OPB_BE = '0;
  logic [0:31]          OPB_DBus = '0;
  logic                 OPB_RNW = 1'b0;
  logic                 OPB_select = 1'b0;
  logic                 OPB_seqAddr = 1'b0;
  logic [0:31]          Sl_DBus;
  logic                 Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [NWords*32-1:0] status_in = '0;
  logic                 snap_pulse;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [31:0] off;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  opb_status_snapshot_ctrl #(.N_WORDS(NWords)) dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst     (OPB_Rst),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_xferAck  (Sl_xferAck),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .status_in   (status_in),
    .snap_pulse  (snap_pulse)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  always @(negedge OPB_Clk) if (snap_pulse === 1'b1) pulse_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  function automatic vec_t mk(input string name, input logic [31:0] off, input logic rnw,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] exp);
    vec_t v;
    v.name = name; v.off = off; v.rnw = rnw; v.be = be; v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0;
    OPB_Rst = 1'b1;
    @(negedge OPB_Clk);
    check("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
    check("rst_dbus", Sl_DBus, 32'h0);
    check("rst_pulse", {31'b0, snap_pulse}, 32'h0);
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
  endtask

  // Called just after a negedge with the slave idle; returns with the slave idle again.
  task automatic bus_xfer(input string name, input logic [31:0] addr, input logic rnw,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp);
    int  cyc;
    bit  got;
    sb_t e;
    e.name = name;
    e.data = rnw ? exp : 32'h0;
    sb_q.push_back(e);
    OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = rnw ? 32'h0 : wdata;
    OPB_select = 1'b1;
    check({name, " pre_dbus"}, Sl_DBus, 32'h0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge OPB_Clk);
      cyc++;
      if (Sl_xferAck === 1'b1) got = 1'b1;
    end
    check({name, " ack_latency"}, 32'(cyc), 32'd1);
    e = sb_q.pop_front();
    if (got) check({e.name, " data"}, Sl_DBus, e.data);
    OPB_select = 1'b0; OPB_DBus = '0;
    @(negedge OPB_Clk);
    check({name, " gap_ack"}, {31'b0, Sl_xferAck}, 32'h0);
    check({name, " gap_dbus"}, Sl_DBus, 32'h0);
    @(negedge OPB_Clk);
  endtask

  task automatic miss_check(input string name, input logic [31:0] addr);
    bit got;
    got = 1'b0;
    OPB_ABus = addr; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck === 1'b1) got = 1'b1;
    end
    OPB_select = 1'b0;
    n_cmp++;
    if (got) begin
      n_fail++;
      $display("FAIL %s: got ack=1 expected no ack", name);
    end
    @(negedge OPB_Clk);
  endtask

  task automatic wait_pulse(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (!ok && cycles < budget) begin
      @(negedge OPB_Clk);
      cycles++;
      if (snap_pulse === 1'b1) ok = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    bit ok;
    int p0;

    // Register map table: reset values, byte enables, unmapped offsets, address edges.
    vecs.push_back(mk("rd_cnt_rst",   32'h08, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_ctrl_rst",  32'h00, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_per_rst",   32'h04, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_0c",        32'h0C, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_sh0_rst",   32'h10, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("wr_per_be03",  32'h04, 1'b0, 4'b0011, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk("rd_per_be03",  32'h04, 1'b1, 4'b1111, 32'h0,         32'h0000_FFFF));
    vecs.push_back(mk("wr_per_be8",   32'h04, 1'b0, 4'b1000, 32'hAABB_CCDD, 32'h0));
    vecs.push_back(mk("rd_per_be8",   32'h04, 1'b1, 4'b1111, 32'h0,         32'hAA00_FFFF));
    vecs.push_back(mk("wr_per_be4",   32'h04, 1'b0, 4'b0100, 32'h1122_3344, 32'h0));
    vecs.push_back(mk("rd_per_be4",   32'h04, 1'b1, 4'b1111, 32'h0,         32'hAA22_FFFF));
    vecs.push_back(mk("wr_fc",        32'hFC, 1'b0, 4'b1111, 32'h1234_5678, 32'h0));
    vecs.push_back(mk("rd_fc",        32'hFC, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_per_keep",  32'h04, 1'b1, 4'b1111, 32'h0,         32'hAA22_FFFF));
    vecs.push_back(mk("rd_per_unal",  32'h06, 1'b1, 4'b1111, 32'h0,         32'hAA22_FFFF));
    vecs.push_back(mk("wr_ctrl_nobe", 32'h00, 1'b0, 4'b1110, 32'h0000_0003, 32'h0));
    vecs.push_back(mk("rd_ctrl_nobe", 32'h00, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_cnt_nosnp", 32'h08, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_30_unmap",  32'h30, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_sh7",       32'h2C, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_highaddr",  32'hFF, 1'b1, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("wr_per_zero",  32'h04, 1'b0, 4'b1111, 32'h0,         32'h0));
    vecs.push_back(mk("rd_per_zero",  32'h04, 1'b1, 4'b1111, 32'h0,         32'h0));

    do_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < vecs.size(); i++) begin
      bus_xfer(vecs[i].name, Base + vecs[i].off, vecs[i].rnw, vecs[i].be, vecs[i].wdata,
               vecs[i].exp);
    end
    check("table_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    miss_check("miss_above", Base + 32'h100);
    miss_check("miss_below", Base - 32'h4);

    // Manual snapshot: shadows hold the values present on the snapshot edge.
    do_reset();
    for (int i = 0; i < int'(NWords); i++) status_in[32*i +: 32] = 32'h1000_0000 + 32'(i);
    status_in[32*3 +: 32] = 32'hDEAD_BEEF;
    p0 = pulse_cnt;
    bus_xfer("man_snap", Base + 32'h00, 1'b0, 4'b1111, 32'h1, 32'h0);
    check("man_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    status_in[32*3 +: 32] = 32'h1234_5678;
    bus_xfer("man_rd_sh3", Base + 32'h1C, 1'b1, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    bus_xfer("man_rd_sh0", Base + 32'h10, 1'b1, 4'b1111, 32'h0, 32'h1000_0000);
    bus_xfer("man_rd_sh7", Base + 32'h2C, 1'b1, 4'b1111, 32'h0, 32'h1000_0007);
    bus_xfer("man_rd_cnt", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'h1);
    bus_xfer("man_rd_ctrl", Base + 32'h00, 1'b1, 4'b1111, 32'h0, 32'h0);
    bus_xfer("man_snap_auto", Base + 32'h00, 1'b0, 4'b1111, 32'h3, 32'h0);
    bus_xfer("man_rd_ctrl2", Base + 32'h00, 1'b1, 4'b1111, 32'h0, 32'h2);
    bus_xfer("man_rd_cnt2", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'h2);
    bus_xfer("man_rd_sh3b", Base + 32'h1C, 1'b1, 4'b1111, 32'h0, 32'h1234_5678);
    bus_xfer("man_ctrl_off", Base + 32'h00, 1'b0, 4'b1111, 32'h0, 32'h0);

    // Counter wrap: preset the count while no snapshot is pending, then snapshot twice.
    force dut.snap_count_q = 32'hFFFF_FFFE;
    @(negedge OPB_Clk);
    release dut.snap_count_q;
    bus_xfer("wrap_snap1", Base + 32'h00, 1'b0, 4'b1111, 32'h1, 32'h0);
    bus_xfer("wrap_rd1", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'hFFFF_FFFF);
    bus_xfer("wrap_snap2", Base + 32'h00, 1'b0, 4'b1111, 32'h1, 32'h0);
    bus_xfer("wrap_rd2", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'h0);

    // Auto mode: pulses exactly PERIOD cycles apart, stopped by PERIOD=0.
    do_reset();
    bus_xfer("auto_per", Base + 32'h04, 1'b0, 4'b1111, 32'd10, 32'h0);
    bus_xfer("auto_en", Base + 32'h00, 1'b0, 4'b1111, 32'h2, 32'h0);
    wait_pulse(30, cyc, ok);
    check("auto_first", {31'b0, ok}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      wait_pulse(30, cyc, ok);
      check($sformatf("auto_interval%0d", k), 32'(cyc), 32'd10);
    end
    bus_xfer("auto_per0", Base + 32'h04, 1'b0, 4'b1111, 32'h0, 32'h0);
    bus_xfer("auto_rd_cnt", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'd5);
    p0 = pulse_cnt;
    repeat (40) @(negedge OPB_Clk);
    check("auto_stopped", 32'(pulse_cnt - p0), 32'd0);

    // Manual SNAP acknowledged in the very cycle the timer fires: one snapshot only.
    do_reset();
    p0 = pulse_cnt;
    bus_xfer("sim_per", Base + 32'h04, 1'b0, 4'b1111, 32'd10, 32'h0);
    bus_xfer("sim_en", Base + 32'h00, 1'b0, 4'b1111, 32'h2, 32'h0);
    wait_pulse(30, cyc, ok);
    check("sim_first", {31'b0, ok}, 32'h1);
    repeat (9) @(negedge OPB_Clk);
    bus_xfer("sim_both", Base + 32'h00, 1'b0, 4'b1111, 32'h3, 32'h0);
    bus_xfer("sim_off", Base + 32'h00, 1'b0, 4'b1111, 32'h0, 32'h0);
    check("sim_pulses", 32'(pulse_cnt - p0), 32'd2);
    bus_xfer("sim_rd_cnt", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'd2);

    // Asynchronous reset in the middle of an acknowledge.
    do_reset();
    bus_xfer("ar_per", Base + 32'h04, 1'b0, 4'b1111, 32'h55, 32'h0);
    status_in[32*3 +: 32] = 32'hCAFE_F00D;
    bus_xfer("ar_snap", Base + 32'h00, 1'b0, 4'b1111, 32'h1, 32'h0);
    bus_xfer("ar_rd_sh3", Base + 32'h1C, 1'b1, 4'b1111, 32'h0, 32'hCAFE_F00D);
    OPB_ABus = Base + 32'h04; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    @(negedge OPB_Clk);
    check("ar_ack_pre", {31'b0, Sl_xferAck}, 32'h1);
    check("ar_data_pre", Sl_DBus, 32'h55);
    #2 OPB_Rst = 1'b1;
    #1;
    check("ar_ack_drop", {31'b0, Sl_xferAck}, 32'h0);
    check("ar_dbus_drop", Sl_DBus, 32'h0);
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    check("ar_reack", {31'b0, Sl_xferAck}, 32'h1);
    check("ar_redata", Sl_DBus, 32'h0);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    @(negedge OPB_Clk);
    bus_xfer("ar_rd_cnt", Base + 32'h08, 1'b1, 4'b1111, 32'h0, 32'h0);
    bus_xfer("ar_rd_sh3b", Base + 32'h1C, 1'b1, 4'b1111, 32'h0, 32'h0);
    bus_xfer("ar_rd_ctrl", Base + 32'h00, 1'b1, 4'b1111, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
